// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: runs one SD SPI-mode command (CRC7 fetch, 6-byte frame, R1 poll).
// Latency: crc_start 1 cycle after acceptance; each SPI byte costs 1 load cycle plus SPI time.
// Backpressure: cmd_ready only in IDLE; CRC/SPI strobes are sampled only in their wait states.
module sd_cmd_sequencer #(
   parameter int NCR_MAX      = 8,
   parameter int CRC_WAIT_MAX = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [5:0]  i_cmd_idx,
   input  logic [31:0] i_cmd_arg,
   output logic        o_crc_start,
   output logic [39:0] o_crc_data,
   input  logic        i_crc_done,
   input  logic [7:0]  i_crc_result,
   output logic        o_spi_go,
   output logic [7:0]  o_spi_txd,
   input  logic        i_spi_done,
   input  logic [7:0]  i_spi_rxd,
   output logic        o_busy,
   output logic        o_done,
   output logic [7:0]  o_r1,
   output logic        o_timeout,
   output logic        o_crc_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRC_REQ,
      S_CRC_WAIT,
      S_TX_LOAD,
      S_TX_WAIT,
      S_RSP_LOAD,
      S_RSP_WAIT,
      S_FINISH
   } state_t;

   localparam logic [7:0]  LP_NCR_LAST = 8'(NCR_MAX);
   localparam logic [15:0] LP_CRC_LAST = 16'(CRC_WAIT_MAX - 1);

   state_t      r_state;
   logic        r_cmd_ready;
   logic        r_busy;
   logic        r_crc_start;
   logic [39:0] r_crc_data;
   logic [6:0]  r_crc7;
   logic        r_spi_go;
   logic [7:0]  r_spi_txd;
   logic        r_done;
   logic [7:0]  r_r1;
   logic        r_timeout;
   logic        r_crc_err;
   logic [2:0]  r_k;
   logic [7:0]  r_poll;
   logic [15:0] r_wait_cnt;

   logic [2:0]  w_tx_sel;
   logic [7:0]  w_tx_byte;
   logic        w_unused_crc_msb;

   // CRC engine's top result bit carries nothing for CRC7
   assign w_unused_crc_msb = i_crc_result[7];

   // Next frame byte: byte 0 when leaving CRC_WAIT, byte k+1 when leaving TX_WAIT.
   // The latched CRC input word already holds {01, idx, arg}, so it doubles as the frame source.
   always_comb begin
      w_tx_sel  = (r_state == S_TX_WAIT) ? (r_k + 3'd1) : 3'd0;
      w_tx_byte = 8'hFF;
      case (w_tx_sel)
         3'd0:    w_tx_byte = r_crc_data[39:32];
         3'd1:    w_tx_byte = r_crc_data[31:24];
         3'd2:    w_tx_byte = r_crc_data[23:16];
         3'd3:    w_tx_byte = r_crc_data[15:8];
         3'd4:    w_tx_byte = r_crc_data[7:0];
         3'd5:    w_tx_byte = {r_crc7, 1'b1};
         default: w_tx_byte = 8'hFF;
      endcase
   end

   // Transaction FSM; pulse outputs are set on entry to the state that owns them
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_crc_start <= 1'b0;
         r_crc_data  <= 40'h0;
         r_crc7      <= 7'h0;
         r_spi_go    <= 1'b0;
         r_spi_txd   <= 8'hFF;
         r_done      <= 1'b0;
         r_r1        <= 8'hFF;
         r_timeout   <= 1'b0;
         r_crc_err   <= 1'b0;
         r_k         <= 3'd0;
         r_poll      <= 8'd0;
         r_wait_cnt  <= 16'd0;
      end else begin
         r_crc_start <= 1'b0;
         r_spi_go    <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_crc_data  <= {2'b01, i_cmd_idx, i_cmd_arg};
                  r_r1        <= 8'hFF;
                  r_timeout   <= 1'b0;
                  r_crc_err   <= 1'b0;
                  r_k         <= 3'd0;
                  r_poll      <= 8'd0;
                  r_wait_cnt  <= 16'd0;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_crc_start <= 1'b1;
                  r_state     <= S_CRC_REQ;
               end
            end
            S_CRC_REQ: begin
               r_state <= S_CRC_WAIT;
            end
            S_CRC_WAIT: begin
               if (i_crc_done) begin
                  r_crc7    <= i_crc_result[6:0];
                  r_k       <= 3'd0;
                  r_spi_txd <= w_tx_byte;
                  r_spi_go  <= 1'b1;
                  r_state   <= S_TX_LOAD;
               end else if (r_wait_cnt == LP_CRC_LAST) begin
                  r_crc_err <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= S_FINISH;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            S_TX_LOAD: begin
               r_state <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               if (i_spi_done) begin
                  r_spi_go <= 1'b1;
                  if (r_k == 3'd5) begin
                     r_spi_txd <= 8'hFF;
                     r_poll    <= r_poll + 8'd1;
                     r_state   <= S_RSP_LOAD;
                  end else begin
                     r_k       <= r_k + 3'd1;
                     r_spi_txd <= w_tx_byte;
                     r_state   <= S_TX_LOAD;
                  end
               end
            end
            S_RSP_LOAD: begin
               r_state <= S_RSP_WAIT;
            end
            S_RSP_WAIT: begin
               if (i_spi_done) begin
                  if (!i_spi_rxd[7]) begin
                     r_r1    <= i_spi_rxd;
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end else if (r_poll == LP_NCR_LAST) begin
                     r_r1      <= 8'hFF;
                     r_timeout <= 1'b1;
                     r_done    <= 1'b1;
                     r_state   <= S_FINISH;
                  end else begin
                     r_spi_txd <= 8'hFF;
                     r_spi_go  <= 1'b1;
                     r_poll    <= r_poll + 8'd1;
                     r_state   <= S_RSP_LOAD;
                  end
               end
            end
            S_FINISH: begin
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign o_cmd_ready = r_cmd_ready;
   assign o_busy      = r_busy;
   assign o_crc_start = r_crc_start;
   assign o_crc_data  = r_crc_data;
   assign o_spi_go    = r_spi_go;
   assign o_spi_txd   = r_spi_txd;
   assign o_done      = r_done;
   assign o_r1        = r_r1;
   assign o_timeout   = r_timeout;
   assign o_crc_err   = r_crc_err;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: CRC and SPI responders with programmable delays,
// a list-level model of the expected MOSI stream / R1 / flags / done latency,
// and directed plus randomized transactions.
module tb_sd_cmd_sequencer;

   localparam int NCR = 8;
   localparam int CWM = 16;
   localparam logic [62:0] RST_EXP = {7'b1000000, 8'hFF, 8'hFF, 40'h0};

   logic        clk;
   logic        i_rst;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [5:0]  i_cmd_idx;
   logic [31:0] i_cmd_arg;
   logic        o_crc_start;
   logic [39:0] o_crc_data;
   logic        i_crc_done;
   logic [7:0]  i_crc_result;
   logic        o_spi_go;
   logic [7:0]  o_spi_txd;
   logic        i_spi_done;
   logic [7:0]  i_spi_rxd;
   logic        o_busy;
   logic        o_done;
   logic [7:0]  o_r1;
   logic        o_timeout;
   logic        o_crc_err;

   sd_cmd_sequencer #(.NCR_MAX(NCR), .CRC_WAIT_MAX(CWM)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_idx(i_cmd_idx), .i_cmd_arg(i_cmd_arg),
      .o_crc_start(o_crc_start), .o_crc_data(o_crc_data),
      .i_crc_done(i_crc_done), .i_crc_result(i_crc_result),
      .o_spi_go(o_spi_go), .o_spi_txd(o_spi_txd),
      .i_spi_done(i_spi_done), .i_spi_rxd(i_spi_rxd),
      .o_busy(o_busy), .o_done(o_done), .o_r1(o_r1),
      .o_timeout(o_timeout), .o_crc_err(o_crc_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // per-transaction responder / observation state
   int          cyc, acc_cyc, cs_cyc, done_cyc, start_cyc;
   int          n_acc, n_cs, n_go, n_done, rb_err, cd_err;
   int          crc_due, spi_due, c_dly, d_dly;
   bit          crc_never, spur, hold_v, accepted, done_seen;
   logic [7:0]  crc_val;
   logic [5:0]  cur_idx;
   logic [31:0] cur_arg;
   logic [39:0] exp_cd;
   logic [7:0]  plan [16];
   logic [7:0]  mosi_q [$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [62:0] rst_vec();
      return {o_cmd_ready, o_busy, o_crc_start, o_spi_go, o_done, o_timeout, o_crc_err,
              o_r1, o_spi_txd, o_crc_data};
   endfunction

   // One clock cycle: observe DUT outputs at the falling edge, then drive this cycle's inputs.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (o_crc_start) begin n_cs++; cs_cyc = cyc; crc_due = cyc + c_dly; end
      if (o_spi_go) begin n_go++; mosi_q.push_back(o_spi_txd); spi_due = cyc + d_dly; end
      if (o_done) begin
         n_done++;
         if (!done_seen) done_cyc = cyc;
         done_seen = 1'b1;
      end
      if (o_cmd_ready == o_busy) rb_err++;
      if (accepted && n_go == 0 && !done_seen && o_crc_data !== exp_cd) cd_err++;

      i_crc_done   = 1'b0;
      i_crc_result = 8'($urandom);
      if (accepted && !crc_never && crc_due == cyc) begin
         i_crc_done   = 1'b1;
         i_crc_result = crc_val;
      end else if (spur && (o_crc_start || n_go > 0 || !accepted) && $urandom_range(0, 1) == 1) begin
         i_crc_done = 1'b1;
      end

      i_spi_done = 1'b0;
      i_spi_rxd  = 8'($urandom);
      if (n_go > 0 && spi_due == cyc) begin
         i_spi_done = 1'b1;
         if (n_go > 6) i_spi_rxd = (n_go - 7 < 16) ? plan[n_go - 7] : 8'hFF;
      end else if (spur && (!accepted || (n_go == 0 && !done_seen)) && $urandom_range(0, 1) == 1) begin
         i_spi_done = 1'b1;
      end

      if (accepted) begin
         i_cmd_idx = 6'($urandom);
         i_cmd_arg = $urandom;
      end else begin
         i_cmd_idx = cur_idx;
         i_cmd_arg = cur_arg;
      end
      i_cmd_valid = (cyc >= start_cyc && !done_seen && (!accepted || hold_v));
      if (i_cmd_valid && o_cmd_ready) begin
         n_acc++;
         if (!accepted) acc_cyc = cyc;
         accepted = 1'b1;
      end
   endtask

   task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                          input bit never, input int c, input int d, input bit hold, input bit sp,
                          input int gap, input int abort_go);
      logic [7:0] exp_q [$];
      logic [7:0] exp_r1;
      bit         exp_to, exp_ce;
      int         exp_lat, polls, budget, nchk;
      logic [6:0] c7;

      // reference: expected byte stream, outcome and done latency
      exp_q.delete();
      exp_r1 = 8'hFF; exp_to = 1'b0; exp_ce = 1'b0; polls = 0;
      if (never) begin
         exp_ce  = 1'b1;
         exp_lat = 2 + CWM;
      end else begin
         c7 = crc[6:0];
         exp_q.push_back({2'b01, idx});
         exp_q.push_back(arg[31:24]);
         exp_q.push_back(arg[23:16]);
         exp_q.push_back(arg[15:8]);
         exp_q.push_back(arg[7:0]);
         exp_q.push_back({c7, 1'b1});
         exp_to = 1'b1;
         for (int i = 0; i < NCR; i++) begin
            exp_q.push_back(8'hFF);
            polls++;
            if (plan[i][7] == 1'b0) begin
               exp_r1 = plan[i];
               exp_to = 1'b0;
               break;
            end
         end
         exp_lat = 2 + c + (6 + polls) * (1 + d);
      end

      cur_idx = idx; cur_arg = arg; crc_val = crc; crc_never = never;
      c_dly = c; d_dly = d; hold_v = hold; spur = sp;
      start_cyc = cyc + 1 + gap;
      exp_cd = {2'b01, idx, arg};
      n_acc = 0; n_cs = 0; n_go = 0; n_done = 0; rb_err = 0; cd_err = 0;
      acc_cyc = 0; cs_cyc = 0; done_cyc = 0; crc_due = 0; spi_due = 0;
      accepted = 1'b0; done_seen = 1'b0;
      mosi_q.delete();

      budget = 0;
      while (!(done_seen && cyc > done_cyc) && budget < 3000) begin
         step();
         budget++;
         if (abort_go != 0 && n_go == abort_go) begin
            for (int i = 0; i < abort_go; i++) check_val("pre_rst_byte", 64'(mosi_q[i]), 64'(exp_q[i]));
            #2 i_rst = 1'b1;
            #1 check_val("rst_async_state", 64'(rst_vec()), 64'(RST_EXP));
            accepted = 1'b0; start_cyc = 32'h7fffffff; spur = 1'b0; crc_due = 0; spi_due = 0;
            repeat (3) step();
            i_rst = 1'b0;
            check_val("rst_no_done", 64'(n_done), 64'd0);
            return;
         end
      end

      check_val("done_within_budget", 64'(done_seen), 64'd1);
      check_val("accept_count", 64'(n_acc), 64'd1);
      check_val("crc_start_count", 64'(n_cs), 64'd1);
      check_val("crc_start_latency", 64'(cs_cyc - acc_cyc), 64'd1);
      check_val("crc_data_hold_errs", 64'(cd_err), 64'd0);
      check_val("mosi_byte_count", 64'(mosi_q.size()), 64'(exp_q.size()));
      nchk = (mosi_q.size() < exp_q.size()) ? mosi_q.size() : exp_q.size();
      for (int i = 0; i < nchk; i++) check_val("mosi_byte", 64'(mosi_q[i]), 64'(exp_q[i]));
      check_val("done_pulses", 64'(n_done), 64'd1);
      check_val("done_latency", 64'(done_cyc - acc_cyc), 64'(exp_lat));
      check_val("r1", 64'(o_r1), 64'(exp_r1));
      check_val("timeout", 64'(o_timeout), 64'(exp_to));
      check_val("crc_err", 64'(o_crc_err), 64'(exp_ce));
      check_val("ready_after_done", 64'(o_cmd_ready), 64'd1);
      check_val("ready_busy_errs", 64'(rb_err), 64'd0);
   endtask

   task automatic fill_plan(input logic [7:0] v);
      for (int i = 0; i < 16; i++) plan[i] = v;
   endtask

   initial begin
      i_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd_idx = '0; i_cmd_arg = '0;
      i_crc_done = 1'b0; i_crc_result = '0; i_spi_done = 1'b0; i_spi_rxd = '0;
      cyc = 0; start_cyc = 32'h7fffffff; accepted = 1'b0; spur = 1'b0; hold_v = 1'b0;
      crc_never = 1'b0; crc_due = 0; spi_due = 0; c_dly = 1; d_dly = 1; done_seen = 1'b0;
      n_acc = 0; n_cs = 0; n_go = 0; n_done = 0; rb_err = 0; cd_err = 0;
      cur_idx = '0; cur_arg = '0; crc_val = '0; exp_cd = '0;
      fill_plan(8'hFF);

      #2 i_rst = 1'b1;
      repeat (3) step();
      check_val("reset_state", 64'(rst_vec()), 64'(RST_EXP));
      i_rst = 1'b0;
      repeat (2) step();

      // CMD0: one busy poll then R1=01
      fill_plan(8'hFF); plan[1] = 8'h01;
      run_txn(6'd0, 32'h0, 8'h4A, 1'b0, 1, 1, 1'b0, 1'b0, 0, 0);

      // CMD8: R1 on first poll, 17-cycle turnaround
      fill_plan(8'hFF); plan[0] = 8'h01;
      run_txn(6'd8, 32'h1AA, 8'h43, 1'b0, 1, 1, 1'b0, 1'b0, 1, 0);

      // NCR expiry: card never answers
      fill_plan(8'hFF);
      run_txn(6'd17, 32'h0000_2000, 8'h2B, 1'b0, 2, 1, 1'b0, 1'b0, 0, 0);

      // CRC engine silent
      run_txn(6'd55, 32'h0, 8'h00, 1'b1, 1, 1, 1'b0, 1'b0, 2, 0);

      // reset after byte 2, then a clean CMD0
      fill_plan(8'hFF); plan[1] = 8'h01;
      run_txn(6'd17, 32'hDEAD_BEEF, 8'h11, 1'b0, 1, 2, 1'b0, 1'b0, 0, 3);
      run_txn(6'd0, 32'h0, 8'h4A, 1'b0, 1, 1, 1'b0, 1'b0, 0, 0);

      // cmd_valid held, spurious strobes
      fill_plan(8'hFF); plan[2] = 8'h00;
      run_txn(6'd55, 32'h0, 8'h65, 1'b0, 4, 1, 1'b1, 1'b1, 3, 0);

      for (int t = 0; t < 12; t++) begin
         logic [7:0] b;
         for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            b[7] = ($urandom_range(0, 3) != 0);
            plan[i] = b;
         end
         run_txn(6'($urandom), $urandom, 8'($urandom), ($urandom_range(0, 7) == 0),
                 $urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Sequences one SD-card SPI-mode command transaction from start to finish.
- Latches a command index and 32-bit argument.
- Obtains CRC7 from the shared CRC engine through a start/done handshake.
- Shifts the 6-byte command frame out through the byte-level SPI master.
- Polls 0xFF bytes until an R1 response arrives or the NCR limit expires.
- Sits between the SD init/read FSMs (requesters) and the CRC/SPI datapath blocks.

Parameters:
NCR_MAX, 8, maximum number of 0xFF poll bytes sent while waiting for R1 (1..255).
CRC_WAIT_MAX, 1024, maximum clk cycles to wait for crc_done before aborting (1..65535).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command request from requester.
cmd_ready  out  1  high when the block can accept a command (IDLE state only).
cmd_idx  in  6  SD command index.
cmd_arg  in  32  SD command argument.
crc_start  out  1  one-cycle start pulse to the CRC engine.
crc_data  out  40  CRC input {2'b01, idx, arg}; held stable from crc_start until crc_done.
crc_done  in  1  CRC engine completion strobe.
crc_result  in  8  CRC engine result; bits [6:0] are CRC7.
spi_go  out  1  one-cycle request to the SPI master to transfer spi_txd.
spi_txd  out  8  byte to transmit; held stable until spi_done.
spi_done  in  1  SPI byte-complete strobe.
spi_rxd  in  8  byte received; valid when spi_done=1.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a transaction ends (success or error).
r1  out  8  R1 response byte; held until the next accepted command.
timeout  out  1  set when NCR_MAX expires; held until the next accepted command.
crc_err  out  1  set when CRC_WAIT_MAX expires; held until the next accepted command.

Behaviour:
- Reset (async, any state) values:
  - State goes to IDLE.
  - cmd_ready=1.
  - crc_start, spi_go, busy, done, timeout and crc_err are all 0.
  - r1=8'hFF, spi_txd=8'hFF, crc_data=0.
  - All counters are cleared.
  - A reset during a transfer abandons it with no done pulse.
- States:
  - IDLE: the command is accepted when cmd_valid=1. On acceptance, latch idx/arg, clear r1 to 8'hFF, clear timeout and crc_err, and go to CRC_REQ.
  - CRC_REQ: assert crc_start for exactly 1 cycle, then go to CRC_WAIT.
  - CRC_WAIT: on crc_done=1, latch crc_result[6:0] and go to TX_LOAD. If CRC_WAIT_MAX cycles elapse first, set crc_err and go to FINISH.
  - TX_LOAD: drive spi_txd with frame byte k and pulse spi_go, then go to TX_WAIT. Frame bytes are:
    - byte0 = {2'b01, idx}
    - bytes1-4 = arg[31:24], arg[23:16], arg[15:8], arg[7:0]
    - byte5 = {crc7, 1'b1}
  - TX_WAIT: on spi_done, increment k. If k was 5, go to RSP_LOAD; otherwise go to TX_LOAD.
  - RSP_LOAD: drive spi_txd=8'hFF, pulse spi_go, increment the poll count, then go to RSP_WAIT.
  - RSP_WAIT: on spi_done, branch as follows:
    - spi_rxd[7]=0: r1<=spi_rxd, go to FINISH.
    - Otherwise, if poll count == NCR_MAX: r1<=8'hFF, set timeout, go to FINISH.
    - Otherwise: go to RSP_LOAD.
  - FINISH: pulse done for 1 cycle, return to IDLE.
- Handshake rules:
  - cmd_valid is ignored while busy=1, because cmd_ready=0.
  - crc_done is sampled only in CRC_WAIT; spi_done is sampled only in TX_WAIT/RSP_WAIT. Strobes in any other state are ignored.
  - crc_done in the same cycle as crc_start is not honoured.
- Latency:
  - Acceptance to crc_start: 1 cycle.
  - Each byte costs 1 cycle plus the SPI time. With 1-cycle SPI/CRC responders, a first-poll R1 gives done 17 cycles after acceptance.
- The poll counter is 8 bits and never wraps; it is compared before incrementing past NCR_MAX.
- A new command may be accepted in the cycle after FINISH (IDLE).

Test Plan:
1. CMD0, arg=0, bench CRC model returns 8'h4A; SPI responder returns FF then 01 -> MOSI bytes 40 00 00 00 00 95 FF FF; r1=01; done pulses once; timeout=0.
2. CMD8, arg=32'h1AA, CRC returns 8'h43 -> bytes 48 00 00 01 AA 87; crc_data=40'h48000001AA during the wait; R1=01 on the first poll.
3. NCR_MAX=8, responder returns all FF -> exactly 8 poll bytes; timeout=1; r1=FF; a single done pulse.
4. CRC engine never asserts done, CRC_WAIT_MAX=16 -> crc_err=1 and done 16 cycles after CRC_WAIT entry; no spi_go ever issued.
5. rst asserted mid-frame after byte 2 -> outputs return to reset values immediately; no done pulse; a following CMD0 completes normally.
6. cmd_valid held high through a transaction, plus spurious spi_done in IDLE and CRC_WAIT -> only one command accepted per IDLE visit; spurious strobes have no effect.
